// File: rtl/vc_plane_scheduler_pkg.sv
// Shared router package for the VC plane scheduler.
// Contents: plane-index width helper, scheduler state enum and the largest
// supported inter-plane bubble length.
package vc_plane_scheduler_pkg;

  localparam int unsigned SWITCH_BUBBLE_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUBBLE
  } sched_state_t;

  // Width of an index over `planes` planes; never narrower than one bit.
  function automatic int unsigned plane_width(input int unsigned planes);
    return (planes <= 1) ? 1 : $clog2(planes);
  endfunction

endpackage

// File: rtl/vc_plane_scheduler_rr_plane_arbiter.sv
// Combinational rotating-priority picker.
// Ports:
//   request  in  N  one bit per plane wanting service
//   ptr      in  W  plane with highest priority this pick
//   winner   out W  lowest requesting index >= ptr, else lowest below ptr
//   found    out 1  any request bit set
module rr_plane_arbiter #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] request,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         found
);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && request[i] && (i >= 32'(ptr))) begin
        found  = 1'b1;
        winner = W'(i);
      end
    end
    // Wrap-around pass: anything left is below the pointer.
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && request[i]) begin
        found  = 1'b1;
        winner = W'(i);
      end
    end
  end

endmodule

// File: rtl/vc_plane_scheduler.sv
// Time-multiplexes one router pipeline among VC+1 virtual-channel planes.
// Round-robin over requesting planes, per-grant flit quantum, lock that pins
// the active plane, and an optional all-zero bubble between planes.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   plane_request     per-plane: flit waiting
//   plane_lock        per-plane: mid-handshake/packet, do not switch away
//   plane_transfer    per-plane: one flit handshake completed this cycle
//   VCPlaneSelector   one-hot active plane or all-zero (registered)
//   grant_valid       |VCPlaneSelector (registered)
//   current_plane     index of active / last-granted plane (registered)
//   quantum_expired   one-cycle pulse when a grant ends on quantum (registered)
module vc_plane_scheduler
  import vc_plane_scheduler_pkg::*;
#(
  parameter int unsigned VC            = 4,
  parameter int unsigned QUANTUM       = 8,
  parameter int unsigned SWITCH_BUBBLE = 1,
  parameter int unsigned PLANE_WIDTH   = plane_width(VC + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [VC:0]            plane_request,
  input  logic [VC:0]            plane_lock,
  input  logic [VC:0]            plane_transfer,
  output logic [VC:0]            VCPlaneSelector,
  output logic                   grant_valid,
  output logic [PLANE_WIDTH-1:0] current_plane,
  output logic                   quantum_expired
);

  localparam int unsigned COUNT_WIDTH = $clog2(QUANTUM + 1);
  localparam logic [COUNT_WIDTH-1:0] QUANTUM_C = COUNT_WIDTH'(QUANTUM);
  localparam logic [3:0] BUBBLE_C =
    4'((SWITCH_BUBBLE > SWITCH_BUBBLE_MAX) ? SWITCH_BUBBLE_MAX : SWITCH_BUBBLE);
  localparam logic [PLANE_WIDTH-1:0] LAST_PLANE = PLANE_WIDTH'(VC);

  sched_state_t           state, state_n;
  logic [COUNT_WIDTH-1:0] count, count_n;
  logic [3:0]             bubble, bubble_n;
  logic [PLANE_WIDTH-1:0] rr_ptr, rr_n;
  logic [PLANE_WIDTH-1:0] plane_n;
  logic                   qexp_n;
  logic [VC:0]            sel_n;

  logic [VC:0]            cur_onehot;
  logic [PLANE_WIDTH-1:0] next_after_cur;
  logic                   cur_req, cur_lock, cur_xfer, others, at_quantum;
  logic [PLANE_WIDTH-1:0] arb_ptr, arb_winner;
  logic                   arb_found;

  always_comb begin
    cur_onehot     = {{VC{1'b0}}, 1'b1} << current_plane;
    next_after_cur = (current_plane == LAST_PLANE) ? '0
                                                   : current_plane + PLANE_WIDTH'(1);
    cur_req        = |(plane_request  & cur_onehot);
    cur_lock       = |(plane_lock     & cur_onehot);
    cur_xfer       = |(plane_transfer & cur_onehot);
    others         = |(plane_request  & ~cur_onehot);
    at_quantum     = (count == QUANTUM_C);
    // A yield from GRANT re-arbitrates from the plane after the current one,
    // so a quantum-expired plane sorts last in the very next pick.
    arb_ptr        = (state == GRANT) ? next_after_cur : rr_ptr;
  end

  rr_plane_arbiter #(
    .N(VC + 1),
    .W(PLANE_WIDTH)
  ) u_arb (
    .request(plane_request),
    .ptr    (arb_ptr),
    .winner (arb_winner),
    .found  (arb_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      bubble          <= '0;
      rr_ptr          <= '0;
      current_plane   <= '0;
      VCPlaneSelector <= '0;
      grant_valid     <= 1'b0;
      quantum_expired <= 1'b0;
    end else begin
      state           <= state_n;
      count           <= count_n;
      bubble          <= bubble_n;
      rr_ptr          <= rr_n;
      current_plane   <= plane_n;
      VCPlaneSelector <= sel_n;
      grant_valid     <= |sel_n;
      quantum_expired <= qexp_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    bubble_n = bubble;
    rr_n     = rr_ptr;
    plane_n  = current_plane;
    qexp_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_found) begin
          state_n = GRANT;
          plane_n = arb_winner;
          count_n = '0;
        end
      end
      GRANT: begin
        if (!cur_lock && (!cur_req || (at_quantum && others))) begin
          rr_n    = next_after_cur;
          // Request still up means the quantum forced the switch.
          qexp_n  = cur_req;
          count_n = '0;
          if (BUBBLE_C != '0) begin
            state_n  = BUBBLE;
            bubble_n = BUBBLE_C;
          end else if (arb_found) begin
            state_n = GRANT;
            plane_n = arb_winner;
          end else begin
            state_n = IDLE;
          end
        end else if (!cur_lock && at_quantum) begin
          // Quantum used up with nobody waiting: start a fresh quantum in place.
          count_n = '0;
        end else if (cur_xfer && (count < QUANTUM_C)) begin
          count_n = count + COUNT_WIDTH'(1);
        end
      end
      BUBBLE: begin
        if (bubble <= 4'd1) begin
          bubble_n = '0;
          if (arb_found) begin
            state_n = GRANT;
            plane_n = arb_winner;
            count_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bubble_n = bubble - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sel_n = '0;
    if (state_n == GRANT) sel_n = {{VC{1'b0}}, 1'b1} << plane_n;
  end

endmodule

// File: doc/vc_plane_scheduler.md
# vc_plane_scheduler

Time-multiplexes one router pipeline among its VC+1 virtual-channel planes by driving the one-hot `VCPlaneSelector` bus shared by all ports and the switch control. Round-robin arbitration over planes with pending traffic, a per-grant quantum of flit transfers, a lock that forbids switching mid-handshake, and a configurable all-zero bubble between planes so reservation state settles. Sits beside the router pipeline, one instance per router.

## Interface
Parameters:
- `VC`, 4, highest plane index; planes are 0..VC (VC+1 planes)
- `QUANTUM`, 8, flit transfers a plane may make per grant before yielding (>=1)
- `SWITCH_BUBBLE`, 1, idle cycles (selector all-zero) between planes (0..15)
- `PLANE_WIDTH`, $clog2(VC+1), derived, width of plane index

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `plane_request`  in  VC+1  bit p: plane p has a flit waiting at any input
- `plane_lock`  in  VC+1  bit p: plane p is mid-handshake (valid high, ready low) or mid-packet; must not be switched away
- `plane_transfer`  in  VC+1  bit p: one flit handshake completed on plane p this cycle
- `VCPlaneSelector`  out  VC+1  one-hot active plane, or all-zero
- `grant_valid`  out  1  high when VCPlaneSelector is non-zero
- `current_plane`  out  PLANE_WIDTH  index of active/last-granted plane
- `quantum_expired`  out  1  one-cycle pulse when a grant ends due to quantum

## Operation
- States: IDLE, GRANT, BUBBLE.
- IDLE: selector 0. If any `plane_request` bit, pick winner by round-robin starting at `rr_ptr`; next cycle GRANT with selector = one-hot(winner), `current_plane` = winner, `count` = 0.
- GRANT: `count` increments on `plane_transfer[current_plane]`; transfer bits of other planes ignored. Saturates at QUANTUM.
- Yield condition: `plane_lock[current_plane]`==0 and (`plane_request[current_plane]`==0 or (`count`==QUANTUM and some other plane requesting)).
- `count`==QUANTUM with no other requester: `count` reset to 0, stay GRANT, no pulse.
- On yield: `rr_ptr` = current_plane+1 (wraps VC->0); `quantum_expired` pulses if quantum caused it. If SWITCH_BUBBLE>0 go BUBBLE with bubble counter = SWITCH_BUBBLE; else re-arbitrate same cycle and go GRANT (winner) or IDLE (none).
- BUBBLE: selector 0; decrement counter; at 1, arbitrate: winner -> GRANT, none -> IDLE.
- Lock dominates: while `plane_lock[current_plane]` high the grant holds regardless of count or request.
- Round-robin: lowest index p >= rr_ptr requesting, else lowest index < rr_ptr requesting. A plane yielding by quantum cannot win the immediately following arbitration if any other plane requests.

## Timing
- All outputs registered. Reset values: selector 0, `grant_valid` 0, `current_plane` 0, `quantum_expired` 0; state IDLE, `rr_ptr` 0, counters 0.
- IDLE->GRANT latency: request at cycle t, selector valid t+1.
- Yield decided on cycle t inputs; selector 0 from t+1 for SWITCH_BUBBLE cycles, new plane at t+1+SWITCH_BUBBLE.
- SWITCH_BUBBLE=0: back-to-back planes, selector changes one-hot to one-hot in one edge, never passes through two-hot.
- Selector is never multi-hot; `grant_valid` == |selector every cycle.
- Reset mid-grant: next cycle all outputs at reset values, pending lock ignored.
- Request and lock both dropping same cycle as quantum: treated as request-drop yield, no pulse.

## Structure
- Shared router package: plane-index width function, state enum, SWITCH_BUBBLE max constant.
- One sub-module `rr_plane_arbiter`: combinational rotating-priority pick (request vector, pointer) -> winner index + found flag; reusable by switch control.

## Test plan
- Reset, then `plane_request`=5'b00100 at cycle 2 -> selector 5'b00100 at cycle 3, `current_plane`=2, `grant_valid`=1.
- QUANTUM=8, plane 0 and 3 requesting, 8 transfers on plane 0 -> `quantum_expired` pulse, selector 0 for 1 cycle, then 5'b01000.
- Same as above with `plane_lock[0]` held 4 extra cycles -> selector stays 5'b00001 until lock drops, then yields.
- All planes requesting continuously, QUANTUM=1 -> grant order 0,1,2,3,4,0 with bubble between each.
- Single requester plane 1, 20 transfers -> selector stays 5'b00010 throughout, no pulse.
- Assert `rst` during GRANT of plane 4 -> next cycle selector 0, `current_plane` 0; next arbitration starts from plane 0.
